// File: rtl/pwm_capture.sv
// PWM capture: measures on-duration and period of pwmIn in clock cycles.
// Optional 3-sample majority glitch filter enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enableC,
  input  logic                pwmIn,
  output logic [NUM_BITS-1:0] highCount,
  output logic [NUM_BITS-1:0] periodCount,
  output logic                valid,
  output logic                overflow
);

  localparam logic [NUM_BITS-1:0] CNT_MAX = '1;
  localparam logic [NUM_BITS-1:0] CNT_ONE = NUM_BITS'(1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t              r_state, w_state_n;
  logic [NUM_BITS-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [NUM_BITS-1:0] r_high, w_high_n;
  logic [NUM_BITS-1:0] r_hc, w_hc_n;
  logic [NUM_BITS-1:0] r_pc, w_pc_n;
  logic                r_valid, w_valid_n;
  logic                r_ovf, w_ovf_n;

  logic r_sync1, r_sync2, r_s_d, r_rise, r_fall;
  logic w_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwmIn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [2:0] r_maj;

  always_ff @(posedge clock) begin
    if (reset) r_maj <= '0;
    else       r_maj <= {r_maj[1:0], r_sync2};
  end

  assign w_s = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_maj[2]) | (r_maj[1] & r_maj[2]);
`else
  assign w_s = r_sync2;
`endif

  // Edge detects are registered so the FSM sees a clean one-cycle strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_high  <= '0;
      r_hc    <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_high  <= w_high_n;
      r_hc    <= w_hc_n;
      r_pc    <= w_pc_n;
      r_valid <= w_valid_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // WAIT_RISE also counts so a stuck input is flagged as overflow.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_high_n  = r_high;
    w_hc_n    = r_hc;
    w_pc_n    = r_pc;
    w_valid_n = 1'b0;
    w_ovf_n   = r_ovf;
    if (!enableC) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_n   = '0;
          w_state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (r_rise) begin
            w_cnt_n   = CNT_ONE;
            w_state_n = HIGH;
          end else if (r_cnt == CNT_MAX) begin
            w_ovf_n = 1'b1;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
        HIGH: begin
          if (r_fall) begin
            w_high_n  = r_cnt;
            w_cnt_n   = w_cnt_inc;
            w_state_n = LOW;
          end else if (r_cnt == CNT_MAX) begin
            w_ovf_n   = 1'b1;
            w_state_n = WAIT_RISE;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
        LOW: begin
          if (r_rise) begin
            w_hc_n    = r_high;
            w_pc_n    = r_cnt;
            w_valid_n = 1'b1;
            w_ovf_n   = 1'b0;
            w_cnt_n   = CNT_ONE;
            w_state_n = HIGH;
          end else if (r_cnt == CNT_MAX) begin
            w_ovf_n   = 1'b1;
            w_state_n = WAIT_RISE;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign highCount   = r_hc;
  assign periodCount = r_pc;
  assign valid       = r_valid;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (8-bit and 4-bit instances).
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en8, pwm8, en4, pwm4;
  logic [7:0] hc8, pc8;
  logic [3:0] hc4, pc4;
  logic       v8, ov8, v4, ov4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int v8_cnt = 0, v4_cnt = 0, vcyc8 = 0, rise_cyc = 0;
  int base8, base4;

  always #5 clk = ~clk;

  pwm_capture #(.NUM_BITS(8)) u_dut8 (
    .clock(clk), .reset(rst), .enableC(en8), .pwmIn(pwm8),
    .highCount(hc8), .periodCount(pc8), .valid(v8), .overflow(ov8)
  );

  pwm_capture #(.NUM_BITS(4)) u_dut4 (
    .clock(clk), .reset(rst), .enableC(en4), .pwmIn(pwm4),
    .highCount(hc4), .periodCount(pc4), .valid(v4), .overflow(ov4)
  );

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (v8 === 1'b1) begin
      v8_cnt++;
      vcyc8 = cyc;
    end
    if (v4 === 1'b1) v4_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive8(input logic v, input int n);
    pwm8 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive4(input logic v, input int n);
    pwm4 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic period8(input int h, input int p);
    drive8(1'b1, h);
    drive8(1'b0, p - h);
  endtask

  task automatic period4(input int h, input int p);
    drive4(1'b1, h);
    drive4(1'b0, p - h);
  endtask

  initial begin
    rst = 1'b1; en8 = 1'b0; pwm8 = 1'b0; en4 = 1'b0; pwm4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hc", hc8, 0);
    check("rst_pc", pc8, 0);
    check("rst_valid", v8, 0);
    check("rst_ovf", ov8, 0);
    rst = 1'b0;
    en8 = 1'b1;
    repeat (2) @(negedge clk);

    // Five periods: first rise only arms, four reports follow
    for (int i = 0; i < 5; i++) period8(30, 100);
    check("p5_count", v8_cnt, 4);
    check("p5_hc", hc8, 30);
    check("p5_pc", pc8, 100);
    check("p5_ovf", ov8, 0);

    // Enable dropped mid-HIGH: broken period is discarded
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_hold_hc", hc8, 30);
    check("dis_hold_pc", pc8, 100);
    en8 = 1'b1;
    repeat (2) @(negedge clk);
    period8(30, 100);
    drive8(1'b1, 10);
    base8 = v8_cnt;
    en8 = 1'b0;
    drive8(1'b1, 2);
    en8 = 1'b1;
    drive8(1'b1, 18);
    drive8(0, 70);
    period8(30, 100);
    check("brk_count", v8_cnt - base8, 0);
    check("brk_valid", v8, 0);
    check("brk_hc", hc8, 30);
    check("brk_pc", pc8, 100);
    drive8(1'b1, 8);
    check("brk_next_count", v8_cnt - base8, 1);

    // Constant low after enable saturates into overflow
    en8 = 1'b0;
    pwm8 = 1'b0;
    repeat (3) @(negedge clk);
    en8 = 1'b1;
    base8 = v8_cnt;
    repeat (200) @(negedge clk);
    check("low_ovf_early", ov8, 0);
    repeat (100) @(negedge clk);
    check("low_ovf", ov8, 1);
    check("low_count", v8_cnt - base8, 0);
    period8(10, 20);
    period8(10, 20);
    check("rec_count", v8_cnt - base8, 1);
    check("rec_hc", hc8, 10);
    check("rec_pc", pc8, 20);
    check("rec_ovf", ov8, 0);

    // One-cycle low glitch mid-HIGH, then latency of the closing rise
    drive8(1'b1, 15);
    base8 = v8_cnt;
    drive8(1'b0, 1);
    drive8(1'b1, 14);
    drive8(1'b0, 70);
    rise_cyc = cyc;
    drive8(1'b1, 8);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("gl_count", v8_cnt - base8, 1);
    check("gl_hc", hc8, 30);
    check("gl_pc", pc8, 100);
    check("latency", vcyc8 - rise_cyc, 6);
`else
    check("gl_count", v8_cnt - base8, 2);
    check("gl_hc", hc8, 14);
    check("gl_pc", pc8, 84);
    check("latency", vcyc8 - rise_cyc, 4);
`endif

    // One-cycle reset mid-LOW
    drive8(1'b1, 22);
    drive8(1'b0, 40);
    rst = 1'b1;
    drive8(1'b0, 1);
    rst = 1'b0;
    check("mid_rst_hc", hc8, 0);
    check("mid_rst_pc", pc8, 0);
    check("mid_rst_valid", v8, 0);
    check("mid_rst_ovf", ov8, 0);
    base8 = v8_cnt;
    drive8(1'b0, 29);
    period8(30, 100);
    check("post_rst_count0", v8_cnt - base8, 0);
    drive8(1'b1, 8);
    check("post_rst_count1", v8_cnt - base8, 1);
    check("post_rst_hc", hc8, 30);
    check("post_rst_pc", pc8, 100);

    // 4-bit: P=15 reports at saturation value, P=16 overflows
    en4 = 1'b1;
    @(negedge clk);
    base4 = v4_cnt;
    period4(5, 15);
    period4(5, 15);
    check("n4_count", v4_cnt - base4, 1);
    check("n4_hc", hc4, 5);
    check("n4_pc", pc4, 15);
    check("n4_ovf", ov4, 0);
    period4(5, 16);
    base4 = v4_cnt;
    drive4(1'b1, 8);
    check("n4_sat_count", v4_cnt - base4, 0);
    check("n4_sat_ovf", ov4, 1);
    check("n4_sat_hc", hc4, 5);
    check("n4_sat_pc", pc4, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter NUM_BITS, default 4, sets the width of the capture counter and of the result outputs.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enableC  input  1  capture enable; low forces IDLE.
REQ-005 pwmIn  input  1  asynchronous PWM waveform to measure.
REQ-006 highCount  output  NUM_BITS  last measured on-duration, in clock cycles.
REQ-007 periodCount  output  NUM_BITS  last measured period, in clock cycles.
REQ-008 valid  output  1  single-cycle pulse when highCount/periodCount update.
REQ-009 overflow  output  1  sticky flag: counter saturated before the expected edge.

Function
REQ-010 pwmIn SHALL pass through a 2-flop synchronizer; the sync output "s" plus a delayed copy "s_d" form rise (s & ~s_d) and fall (~s & s_d) detects.
REQ-011 FSM states SHALL be IDLE, WAIT_RISE, HIGH, LOW.
REQ-012 IDLE: counter cleared; go to WAIT_RISE when enableC=1.
REQ-013 WAIT_RISE: on rise, load counter=1 and go to HIGH; no result reported.
REQ-014 HIGH: counter increments each cycle; on fall, latch the counter value into an internal high register and go to LOW.
REQ-015 LOW: counter increments; on rise, drive highCount=latched high value and periodCount=counter value, pulse valid for one cycle (registered, the cycle after the rise detect), clear overflow, reload counter=1, go to HIGH.
REQ-016 For a waveform high H cycles, period P cycles (both below 2^NUM_BITS), results SHALL be exactly H and P.
REQ-017 Counter SHALL saturate at 2^NUM_BITS-1; reaching that value in HIGH or LOW with no edge detected that cycle SHALL set overflow and go to WAIT_RISE with no valid pulse.
REQ-018 An edge detected in the same cycle the counter equals 2^NUM_BITS-1 SHALL be processed normally (value reported/latched, no overflow).
REQ-019 enableC=0 in any state SHALL go to IDLE next cycle, discard the partial measurement, hold highCount/periodCount/overflow, and keep valid low; it dominates edge detects.
REQ-020 highCount/periodCount SHALL hold their values between valid pulses.
REQ-021 Constant-high or constant-low pwmIn SHALL therefore produce overflow, never valid.
REQ-022 Latency: valid SHALL rise 4 clocks after the pwmIn rising edge that ends a period (2 sync, 1 detect, 1 output register), with the filter disabled.

Reset
REQ-023 reset=1 SHALL force IDLE, counter=0, synchronizer/filter flops=0, highCount=0, periodCount=0, valid=0, overflow=0 on the next rising clock edge.
REQ-024 reset SHALL dominate enableC and all edge detects; reset mid-measurement discards it, and the first period after release is never reported.

Configuration
REQ-025 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: a 3-sample majority filter SHALL sit between synchronizer and edge detect, rejecting single-cycle pulses and adding 2 cycles to REQ-022 latency; measured H and P SHALL be unchanged.
REQ-026 Macro undefined: no filter; every synchronized transition, including 1-cycle glitches, SHALL be treated as an edge.

Verification
REQ-027 NUM_BITS=8, enableC=1, PWM H=30 P=100 for 5 periods -> first period unreported, then 4 valid pulses each with highCount=30, periodCount=100, overflow=0.
REQ-028 NUM_BITS=8, pwmIn held 0 after enable -> overflow=1 once counter hits 255, no valid; then H=10 P=20 -> valid with 10/20, overflow cleared.
REQ-029 NUM_BITS=4, H=5 P=15 -> valid with 5/15; P=16 -> overflow, no valid (boundary at saturation value 15).
REQ-030 enableC dropped mid-HIGH then re-asserted -> no valid for the broken period; outputs hold previous 30/100 until next full period.
REQ-031 Inject a 1-cycle low glitch mid-HIGH (H=30 P=100): with PWM_CAPTURE_GLITCH_FILTER_EN -> 30/100 reported; without -> glitch splits the period, no 30/100 result that period.
REQ-032 reset asserted for 1 cycle mid-LOW -> all outputs 0 next cycle, no valid until two further rising edges of pwmIn.
